// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader.
// Define MIPS_BOOT_CHECKSUM_EN to add the XOR trailer check (CHECK state).
package mips_boot_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         HDR_LEN       = 3;
  localparam int         COUNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_LOAD,
`ifdef MIPS_BOOT_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the boot loader.
// master = stream source / system side, slave = the loader.
interface mips_boot_loader_if #(
  parameter int ADDR_W = 8
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_run, load_error, words_loaded
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_run, load_error, words_loaded
  );

endinterface

// File: rtl/mips_byte_packer.sv
// Packs accepted payload bytes MSB-first into 32-bit words; word_valid marks
// the 4th byte of each word, with word_data including that byte.
module mips_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  byte_idx;
  logic [23:0] shift_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every register regardless of order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (byte_valid) begin
      byte_idx <= byte_idx + 2'd1;
      shift_q  <= {shift_q[15:0], byte_data};
    end
  end

  // Only three earlier bytes are ever needed: the 4th arrives on the bus.
  assign word_valid = byte_valid && (byte_idx == 2'd3);
  assign word_data  = {shift_q, byte_data};

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: MAGIC, 16-bit word count, payload words written to imem from
// address 0, then core_run. MIPS_BOOT_CHECKSUM_EN adds an XOR trailer byte.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  mips_boot_loader_if.slave  bus
);

  localparam int                 CMP_W    = COUNT_W + 1;
  localparam logic [CMP_W-1:0]   CAPACITY = CMP_W'(1) << ADDR_W;
`ifdef MIPS_BOOT_CHECKSUM_EN
  localparam state_e             END_STATE = ST_CHECK;
`else
  localparam state_e             END_STATE = ST_DONE;
`endif
  localparam bit                 END_RUNS  = (END_STATE == ST_DONE);

  state_e              state;
  logic [7:0]          cnt_hi;
  logic [COUNT_W-1:0]  word_count;
  logic [ADDR_W:0]     word_ptr;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                we_q;
  logic                run_q;
  logic                err_q;
  logic                ready_q;
`ifdef MIPS_BOOT_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic                accept;
  logic                hdr_done;
  logic [COUNT_W-1:0]  count_in;
  logic                pk_valid;
  logic [31:0]         pk_word;

  assign accept   = bus.rx_valid && ready_q;
  assign hdr_done = accept && (state == ST_CNT_LO);
  assign count_in = {cnt_hi, bus.rx_data};

  mips_byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (hdr_done),
    .byte_valid (accept && (state == ST_LOAD)),
    .byte_data  (bus.rx_data),
    .word_valid (pk_valid),
    .word_data  (pk_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt_hi     <= '0;
      word_count <= '0;
      word_ptr   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
`ifdef MIPS_BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      we_q <= 1'b0;  // strobe lasts one cycle unless re-armed below
      if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (bus.rx_data == MAGIC) state <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            cnt_hi <= bus.rx_data;
            state  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            word_count <= count_in;
            word_ptr   <= '0;
`ifdef MIPS_BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
            if (CMP_W'(count_in) > CAPACITY) begin
              state   <= ST_ERROR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else if (count_in == '0) begin
              state   <= END_STATE;
              run_q   <= END_RUNS;
              ready_q <= !END_RUNS;
            end else begin
              state <= ST_LOAD;
            end
          end
          ST_LOAD: begin
`ifdef MIPS_BOOT_CHECKSUM_EN
            csum <= csum ^ bus.rx_data;
`endif
            if (pk_valid) begin
              we_q     <= 1'b1;
              addr_q   <= word_ptr[ADDR_W-1:0];
              wdata_q  <= pk_word;
              word_ptr <= word_ptr + 1'b1;
              if (CMP_W'(word_ptr) + CMP_W'(1) == CMP_W'(word_count)) begin
                state   <= END_STATE;
                run_q   <= END_RUNS;
                ready_q <= !END_RUNS;
              end
            end
          end
`ifdef MIPS_BOOT_CHECKSUM_EN
          ST_CHECK: begin
            ready_q <= 1'b0;
            if (bus.rx_data == csum) begin
              state <= ST_DONE;
              run_q <= 1'b1;
            end else begin
              state <= ST_ERROR;
              err_q <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready     = ready_q;
  assign bus.imem_we      = we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.core_run     = run_q;
  assign bus.load_error   = err_q;
  assign bus.words_loaded = word_ptr;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: stream-level reference model compared
// every cycle, plus literal expectations; follows MIPS_BOOT_CHECKSUM_EN if defined.
module tb_mips_boot_loader;
  import mips_boot_pkg::*;

  localparam int         ADDR_W = 8;
  localparam logic [7:0] MAGIC  = 8'hA5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mips_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- stream-level reference model ----------------
  logic              m_ready, m_we, m_run, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  int                m_words;
  bit                m_framed;
  int                m_hdr;
  int                m_count;
  logic [7:0]        m_pay[$];

  task automatic model_clear();
    m_ready = 1'b1; m_we = 1'b0; m_run = 1'b0; m_err = 1'b0;
    m_addr = '0; m_wdata = '0; m_words = 0;
    m_framed = 1'b0; m_hdr = 0; m_count = 0; m_pay.delete();
  endtask

  task automatic model_payload_end();
`ifndef MIPS_BOOT_CHECKSUM_EN
    m_run = 1'b1; m_ready = 1'b0;
`endif
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (!m_framed) begin
      if (b == MAGIC) begin m_framed = 1'b1; m_hdr = 1; m_count = 0; end
    end else if (m_hdr < HDR_LEN) begin
      m_count = (m_count << 8) | int'(b);
      m_hdr++;
      if (m_hdr == HDR_LEN) begin
        if (m_count > (1 << ADDR_W)) begin m_err = 1'b1; m_ready = 1'b0; end
        else if (m_count == 0) model_payload_end();
      end
    end else if (m_pay.size() < m_count * 4) begin
      m_pay.push_back(b);
      if (m_pay.size() % 4 == 0) begin
        int n;
        n       = m_pay.size();
        m_we    = 1'b1;
        m_words = n / 4;
        m_addr  = ADDR_W'(m_words - 1);
        m_wdata = {m_pay[n-4], m_pay[n-3], m_pay[n-2], m_pay[n-1]};
        if (n == m_count * 4) model_payload_end();
      end
    end else begin
      logic [7:0] x;
      x = 8'h00;
      foreach (m_pay[i]) x ^= m_pay[i];
      m_ready = 1'b0;
      if (x == b) m_run = 1'b1;
      else        m_err = 1'b1;
    end
  endtask

  always @(posedge clock) begin
    if (reset) model_clear();
    else begin
      m_we = 1'b0;
      if (bus.rx_valid && m_ready) model_accept(bus.rx_data);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("rx_ready",     bus.rx_ready,     m_ready);
      check("imem_we",      bus.imem_we,      m_we);
      check("core_run",     bus.core_run,     m_run);
      check("load_error",   bus.load_error,   m_err);
      check("words_loaded", bus.words_loaded, m_words);
      if (m_we) begin
        check("imem_addr",  bus.imem_addr,  m_addr);
        check("imem_wdata", bus.imem_wdata, m_wdata);
      end
    end
  end

  logic [39:0] wlog[$];
  always @(negedge clock)
    if (bus.imem_we === 1'b1) wlog.push_back({bus.imem_addr, bus.imem_wdata});

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle();
      send(s[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wlog.delete();
  endtask

  logic [7:0] basic[$];
  logic [7:0] big[$];
  logic [7:0] s[$];
  logic [7:0] x;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    basic = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef MIPS_BOOT_CHECKSUM_EN
    basic.push_back(8'h66);
`endif

    // reset state, observed while reset is still asserted after two edges
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_ready", bus.rx_ready, 1);
    check("rst_we",    bus.imem_we, 0);
    check("rst_addr",  bus.imem_addr, 0);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_run",   bus.core_run, 0);
    check("rst_err",   bus.load_error, 0);
    check("rst_words", bus.words_loaded, 0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // basic back-to-back load
    send_stream(basic, 1'b0);
    idle();
    check("basic_run_next_cycle", bus.core_run, 1);
`ifndef MIPS_BOOT_CHECKSUM_EN
    check("basic_we_with_run", bus.imem_we, 1);
`endif
    repeat (2) idle();
    check("basic_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("basic_w0", wlog[0], {8'h00, 32'h11223344});
      check("basic_w1", wlog[1], {8'h01, 32'hDEADBEEF});
    end
    check("basic_words", bus.words_loaded, 2);
    check("basic_ready_low", bus.rx_ready, 0);

    // junk prefix and random stalls
    do_reset();
    s = '{8'h3C, 8'h00};
    foreach (basic[i]) s.push_back(basic[i]);
    send_stream(s, 1'b1);
    repeat (3) idle();
    check("junk_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("junk_w0", wlog[0], {8'h00, 32'h11223344});
      check("junk_w1", wlog[1], {8'h01, 32'hDEADBEEF});
    end
    check("junk_err", bus.load_error, 0);
    check("junk_run", bus.core_run, 1);

    // oversize count 257
    do_reset();
    send_stream('{8'hA5, 8'h01, 8'h01}, 1'b0);
    idle();
    check("over_err", bus.load_error, 1);
    check("over_ready", bus.rx_ready, 0);
    send_stream('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 1'b0);
    repeat (2) idle();
    check("over_nwrites", wlog.size(), 0);
    check("over_run", bus.core_run, 0);

    // zero-length load
    do_reset();
`ifdef MIPS_BOOT_CHECKSUM_EN
    send_stream('{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
`else
    send_stream('{8'hA5, 8'h00, 8'h00}, 1'b0);
`endif
    idle();
    check("zero_run", bus.core_run, 1);
    check("zero_words", bus.words_loaded, 0);

`ifdef MIPS_BOOT_CHECKSUM_EN
    // bad trailer
    do_reset();
    s = basic;
    s[s.size()-1] = 8'h67;
    send_stream(s, 1'b0);
    idle();
    check("csum_bad_err", bus.load_error, 1);
    check("csum_bad_run", bus.core_run, 0);
`endif

    // full capacity: 256 words, last address 255
    do_reset();
    big = '{8'hA5, 8'h01, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      big.push_back(8'(i * 7 + 3));
      x ^= 8'(i * 7 + 3);
    end
`ifdef MIPS_BOOT_CHECKSUM_EN
    big.push_back(x);
`endif
    send_stream(big, 1'b0);
    idle();
    check("max_run", bus.core_run, 1);
    check("max_words", bus.words_loaded, 256);
    repeat (2) idle();
    check("max_nwrites", wlog.size(), 256);
    if (wlog.size() == 256) begin
      check("max_first", wlog[0],   {8'h00, 32'h030A1118});
      check("max_last",  wlog[255], {8'hFF, 32'hE7EEF5FC});
    end

    // reset mid-load, with a byte offered during reset
    do_reset();
    for (int i = 0; i < 6; i++) send(basic[i]);
    @(negedge clock);
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h44;
    @(negedge clock);
    reset = 1'b0;
    bus.rx_valid = 1'b0;
    check("mid_words", bus.words_loaded, 0);
    check("mid_ready", bus.rx_ready, 1);
    check("mid_run",   bus.core_run, 0);
    wlog.delete();
    send_stream(basic, 1'b0);
    repeat (3) idle();
    check("mid_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("mid_w0", wlog[0], {8'h00, 32'h11223344});
      check("mid_w1", wlog[1], {8'h01, 32'hDEADBEEF});
    end
    check("mid_run_after", bus.core_run, 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
